pixel_sink_fb: RTL and testbench
================================

Name: pixel_sink_fb

Overview:
- Receiving end of the drawing datapaths' pixel-plot interface: the {plot, X, Y, colour} stream that draw/loadVal datapaths emit, one pixel per cycle.
- Captures plots into a small request FIFO and commits them to an on-chip framebuffer.
- Serves a raster-order readback stream with a valid/ready handshake, for display scan-out or for bench inspection of what was drawn.
- Sits between the game datapaths and the display/compare logic.

Parameters:
- X_W, 7, bits of x coordinate; framebuffer width is 2^X_W.
- Y_W, 7, bits of y coordinate; framebuffer height is 2^Y_W.
- COL_W, 3, colour bits per pixel.
- FIFO_DEPTH, 8, plot request FIFO entries; must be a power of 2 and at least 2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- plot  in  1  pixel write strobe; sampled every cycle.
- x  in  X_W  plot x coordinate.
- y  in  Y_W  plot y coordinate.
- colour  in  COL_W  plot colour.
- overflow  out  1  sticky: a plot arrived while the FIFO was full.
- idle  out  1  high when the FIFO is empty and the scan FSM is in S_IDLE.
- scan_start  in  1  single-cycle pulse; starts a full-frame readback.
- pix_valid  out  1  readback pixel is presented.
- pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready.
- pix_x  out  X_W  readback x.
- pix_y  out  Y_W  readback y.
- pix_col  out  COL_W  readback colour.
- frame_done  out  1  one-cycle pulse in the cycle the last pixel is accepted.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty; overflow=0; scan FSM to S_IDLE; scan address=0.
  - pix_valid=0, frame_done=0, pix_x/pix_y/pix_col=0, idle=1.
  - Framebuffer contents are NOT cleared.
  - Reset mid-scan or mid-drain aborts the operation; pending plots are discarded.
- Plot capture:
  - plot=1 with FIFO not full: {x,y,colour} pushed at the clock edge.
  - plot=1 with FIFO full: request dropped and overflow set; overflow stays set until reset.
  - A push into an empty FIFO is not visible to the drain logic until the next cycle, so push-to-write latency is at least 1 cycle.
- Framebuffer:
  - Single-port synchronous RAM, 2^(X_W+Y_W) x COL_W.
  - Address = {y, x}.
  - Read data is returned 1 cycle after the address is issued.
- Port arbitration:
  - A FIFO drain (pop plus RAM write) has priority whenever the FIFO is non-empty; one write per cycle.
  - A scan read is issued only in a cycle with the FIFO empty.
  - Sustained plot traffic therefore stalls the scan but never loses pixels unless the FIFO overflows.
  - Same-address write-then-read in consecutive cycles returns the new value.
- Scan FSM states:
  - S_IDLE: on scan_start go to S_READ with address=0. scan_start is ignored in every other state.
  - S_READ: if the FIFO is empty, issue a RAM read at the scan address and go to S_WAIT; otherwise stay.
  - S_WAIT: latch RAM data into pix_col and the address into pix_y/pix_x, set pix_valid=1, go to S_HOLD.
  - S_HOLD: hold all pix_* outputs stable while pix_ready=0.
    - On acceptance at the last address (all ones): pulse frame_done, clear pix_valid, reset address to 0, go to S_IDLE.
    - On acceptance otherwise: clear pix_valid, increment address, go to S_READ.
- Throughput: at best 1 pixel per 3 cycles with pix_ready tied high (READ, WAIT, HOLD).
- Raster order: x increments fastest; after x wraps from 2^X_W-1 to 0, y increments.
- A plot to an address that has already been scanned during an active scan is not reflected in the current frame.
- idle is combinational: (FIFO empty) && (state==S_IDLE).

Decomposition:
- Shared package (the team's vga/draw constants package) holds:
  - scan state encodings S_IDLE, S_READ, S_WAIT, S_HOLD;
  - default X_W, Y_W, COL_W;
  - the colour constants used by the drawers (BLACK=3'b000, WHITE=3'b111).
- One natural sub-module: plot_fifo, a parameterised synchronous FIFO with push, pop, full, empty and data, reset the same way.
- Framebuffer RAM is inferred inline.

Test Plan:
- Reset values: assert reset mid-scan, with no clock edges needed → pix_valid=0, overflow=0, idle=1, state S_IDLE.
- Write then readback (X_W=2, Y_W=2): plot (1,2)=3'b111 and (3,3)=3'b101; write all other pixels 0; scan_start with pix_ready=1.
  - 16 pixels arrive in raster order; the pixel at index 9 has pix_col=3'b111; index 15 has 3'b101.
  - frame_done pulses once, with the 16th acceptance.
- Backpressure: hold pix_ready=0 for 5 cycles at pixel 4 → pix_x/pix_y/pix_col stable throughout; no skipped or duplicated coordinates.
- Overflow (FIFO_DEPTH=8): plot every cycle for 12 cycles while a scan is mid-frame.
  - Overflow stays 0, because the FIFO drains at 1 per cycle.
  - Then force 9 pushes with the drain blocked by a combinational double plot via a bench back-door, and check overflow=1 and that it persists until reset.
- Arbitration: plot (0,0)=3'b010 in the same cycle as scan_start → scan returns 3'b010 at pixel 0 (the write wins, the read is stalled).
- scan_start during S_HOLD → ignored; the frame completes with exactly 2^(X_W+Y_W) acceptances.

Source files
------------

// File: rtl/pixel_sink_fb_pkg.sv
// Shared vga/draw constants: scan FSM encodings, default geometry and drawer colours.
package pixel_sink_fb_pkg;

  localparam int DEF_X_W   = 7;
  localparam int DEF_Y_W   = 7;
  localparam int DEF_COL_W = 3;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } scan_state_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous show-ahead FIFO buffering plot requests ahead of the framebuffer port.
module plot_fifo #(
  parameter int DATA_W = 17,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PW:0]       wr_ptr_r;
  logic [PW:0]       rd_ptr_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[PW-1:0]];

  // Read/write pointer advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (PW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pixel_sink_fb.sv
// Pixel-plot sink: FIFO-buffered framebuffer writes plus a raster-order valid/ready readback scan.
module pixel_sink_fb
  import pixel_sink_fb_pkg::*;
#(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int COL_W      = DEF_COL_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             plot,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic [COL_W-1:0] colour,
  output logic             overflow,
  output logic             idle,
  input  logic             scan_start,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic [COL_W-1:0] pix_col,
  output logic             frame_done
);

  localparam int AW   = X_W + Y_W;
  localparam int FD_W = AW + COL_W;

  scan_state_t      state_r;
  scan_state_t      next_state_s;
  logic [AW-1:0]    scan_addr_r;
  logic             last_s;
  logic             rd_en_s;
  logic             drain_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [FD_W-1:0]  fifo_dout_s;
  logic [COL_W-1:0] rd_data_r;
  logic [COL_W-1:0] fb_mem_r [1 << AW];
  logic             overflow_r;
  logic             pix_valid_r;
  logic [X_W-1:0]   pix_x_r;
  logic [Y_W-1:0]   pix_y_r;
  logic [COL_W-1:0] pix_col_r;

  plot_fifo #(
    .DATA_W (FD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (plot),
    .pop   (drain_s),
    .din   ({y, x, colour}),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .dout  (fifo_dout_s)
  );

  // Draining always owns the single RAM port; scan reads only fit into empty-FIFO cycles.
  assign drain_s    = !fifo_empty_s;
  assign last_s     = (scan_addr_r == {AW{1'b1}});
  assign idle       = fifo_empty_s && (state_r == S_IDLE);
  assign frame_done = (state_r == S_HOLD) && pix_ready && last_s;
  assign overflow   = overflow_r;
  assign pix_valid  = pix_valid_r;
  assign pix_x      = pix_x_r;
  assign pix_y      = pix_y_r;
  assign pix_col    = pix_col_r;

  // Framebuffer port: FIFO head write, or scan read with one-cycle latency.
  always_ff @(posedge clock) begin
    if (drain_s) begin
      fb_mem_r[fifo_dout_s[FD_W-1:COL_W]] <= fifo_dout_s[COL_W-1:0];
    end else if (rd_en_s) begin
      rd_data_r <= fb_mem_r[scan_addr_r];
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (plot && fifo_full_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Scan state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Scan next-state and read-issue decode.
  always_comb begin
    next_state_s = state_r;
    rd_en_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (scan_start) next_state_s = S_READ;
        else            next_state_s = S_IDLE;
      end
      S_READ: begin
        if (!drain_s) begin
          rd_en_s      = 1'b1;
          next_state_s = S_WAIT;
        end else begin
          next_state_s = S_READ;
        end
      end
      S_WAIT: next_state_s = S_HOLD;
      S_HOLD: begin
        if (pix_ready) next_state_s = last_s ? S_IDLE : S_READ;
        else           next_state_s = S_HOLD;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Scan address and registered readback outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_addr_r <= {AW{1'b0}};
      pix_valid_r <= 1'b0;
      pix_x_r     <= {X_W{1'b0}};
      pix_y_r     <= {Y_W{1'b0}};
      pix_col_r   <= COL_W'(BLACK);
    end else begin
      case (state_r)
        S_IDLE: scan_addr_r <= {AW{1'b0}};
        S_WAIT: begin
          pix_col_r   <= rd_data_r;
          pix_y_r     <= scan_addr_r[AW-1:X_W];
          pix_x_r     <= scan_addr_r[X_W-1:0];
          pix_valid_r <= 1'b1;
        end
        S_HOLD: begin
          if (pix_ready) begin
            pix_valid_r <= 1'b0;
            scan_addr_r <= last_s ? {AW{1'b0}} : scan_addr_r + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_sink_fb.sv
// Directed bench for pixel_sink_fb on a 4x4 framebuffer: plot table, readback scans, corner sequences.
module tb_pixel_sink_fb;
  import pixel_sink_fb_pkg::*;

  localparam int XW   = 2;
  localparam int YW   = 2;
  localparam int CW   = 3;
  localparam int NPIX = 16;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] col;
    int            exp_idx;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          plot = 1'b0;
  logic [XW-1:0] x = 2'd0;
  logic [YW-1:0] y = 2'd0;
  logic [CW-1:0] colour = 3'd0;
  logic          scan_start = 1'b0;
  logic          pix_ready = 1'b0;
  logic          overflow, idle, pix_valid, frame_done;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_col;

  int            n_checks = 0;
  int            n_errors = 0;
  vec_t          tbl [NPIX];
  logic [CW-1:0] model_fb [NPIX];
  logic [CW-1:0] got_col [NPIX];

  always #5 clock = ~clock;

  pixel_sink_fb #(.X_W(XW), .Y_W(YW), .COL_W(CW), .FIFO_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .overflow(overflow), .idle(idle), .scan_start(scan_start), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_col(pix_col),
    .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 100) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(idle), 32'd1);
  endtask

  // Runs one full frame; optionally stalls at pixel stall_at and pokes scan_start during the stall.
  task automatic do_scan(input int stall_at, input int stall_len, input bit poke);
    int idx = 0;
    int budget = 0;
    int fd = 0;
    int extra = 0;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    logic [CW-1:0] hc;
    scan_start = 1'b1;
    pix_ready  = 1'b1;
    tick();
    scan_start = 1'b0;
    plot       = 1'b0;
    while (idx < NPIX && budget < 2000) begin
      if (pix_valid) begin
        if (idx == stall_at) begin
          pix_ready = 1'b0;
          hx = pix_x; hy = pix_y; hc = pix_col;
          for (int s = 0; s < stall_len; s++) begin
            scan_start = (poke && s == 1);
            tick();
            budget++;
            check("hold_stable", {24'd0, pix_valid, pix_y, pix_x, pix_col}, {24'd0, 1'b1, hy, hx, hc});
          end
          scan_start = 1'b0;
          pix_ready  = 1'b1;
        end
        check("pix_x", 32'(pix_x), 32'(idx % 4));
        check("pix_y", 32'(pix_y), 32'(idx / 4));
        check("pix_col", 32'(pix_col), 32'(model_fb[idx]));
        check("frame_done_pos", 32'(frame_done), 32'(idx == NPIX - 1));
        if (frame_done) fd++;
        got_col[idx] = pix_col;
        idx++;
      end else if (frame_done) begin
        fd++;
      end
      tick();
      budget++;
    end
    check("scan_count", 32'(idx), 32'(NPIX));
    check("frame_done_once", 32'(fd), 32'd1);
    for (int k = 0; k < 12; k++) begin
      if (pix_valid || frame_done) extra++;
      tick();
    end
    check("no_restart", 32'(extra), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      tbl[i].x       = XW'(i % 4);
      tbl[i].y       = YW'(i / 4);
      tbl[i].col     = BLACK;
      tbl[i].exp_idx = i;
    end
    tbl[9]  = '{2'd1, 2'd2, WHITE, 9};
    tbl[15] = '{2'd3, 2'd3, 3'b101, 15};
    for (int i = 0; i < NPIX; i++) model_fb[tbl[i].exp_idx] = tbl[i].col;

    // Reset state
    repeat (3) tick();
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pix_xyc", {24'd0, 1'b0, pix_y, pix_x, pix_col}, 32'd0);
    reset = 1'b0;
    tick();

    // Plot the table in reverse order, one per cycle
    for (int i = NPIX - 1; i >= 0; i--) begin
      plot = 1'b1; x = tbl[i].x; y = tbl[i].y; colour = tbl[i].col;
      tick();
    end
    plot = 1'b0;
    wait_idle();
    check("no_overflow_fill", 32'(overflow), 32'd0);

    do_scan(-1, 0, 1'b0);
    check("pix9_white", 32'(got_col[9]), 32'h7);
    check("pix15_101", 32'(got_col[15]), 32'h5);

    // Backpressure at pixel 4, with an ignored scan_start during the hold
    do_scan(4, 5, 1'b1);

    // Sustained plots while mid-frame only stall the scan
    fork
      do_scan(-1, 0, 1'b0);
      begin
        repeat (10) tick();
        x = 2'd2; y = 2'd0; colour = 3'b000; plot = 1'b1;
        repeat (12) tick();
        plot = 1'b0;
      end
    join
    check("overflow_stream", 32'(overflow), 32'd0);

    // Plot to (0,0) in the same cycle as scan_start: the write lands first
    wait_idle();
    x = 2'd0; y = 2'd0; colour = 3'b010; plot = 1'b1;
    model_fb[0] = 3'b010;
    do_scan(-1, 0, 1'b0);
    check("arb_pix0", 32'(got_col[0]), 32'h2);

    // Block draining so nine plots overrun the 8-entry FIFO
    wait_idle();
    force dut.drain_s = 1'b0;
    x = 2'd1; y = 2'd1; colour = 3'b000; plot = 1'b1;
    repeat (8) tick();
    check("overflow_at_8", 32'(overflow), 32'd0);
    tick();
    check("overflow_at_9", 32'(overflow), 32'd1);
    plot = 1'b0;
    release dut.drain_s;
    wait_idle();
    check("overflow_sticky", 32'(overflow), 32'd1);
    repeat (5) tick();
    check("overflow_sticky2", 32'(overflow), 32'd1);

    // Asynchronous reset in the middle of a scan
    pix_ready = 1'b0;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int n = 0; n < 40 && !pix_valid; n++) tick();
    check("midscan_valid", 32'(pix_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("ares_pix_valid", 32'(pix_valid), 32'd0);
    check("ares_overflow", 32'(overflow), 32'd0);
    check("ares_idle", 32'(idle), 32'd1);
    check("ares_state", 32'(dut.state_r), 32'(S_IDLE));
    tick();
    reset = 1'b0;
    pix_ready = 1'b1;
    repeat (3) tick();
    check("post_reset_valid", 32'(pix_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
